// File: rtl/mem_bist_master_if.sv
// Valid/ready request port between the BIST master (initiator) and a memory (responder).
interface mem_bist_master_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (output valid, wr_rd, addr, wdata, input rdata, ready);
  modport slave  (input valid, wr_rd, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_bist_master.sv
// Memory BIST initiator: write / read-check / write-then-read sweeps with a seed+address pattern.
// Optional request watchdog enabled by defining MEM_BIST_TIMEOUT_EN.
module mem_bist_master #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] s_loc_i,
  input  logic [ADDR_WIDTH:0]   no_of_loc_i,
  input  logic [WIDTH-1:0]      seed_i,
  mem_bist_master_if.master     bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o
);
  localparam int unsigned           CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DEPTH < 2 || TIMEOUT == 0) begin : g_bad_param
    $error("mem_bist_master: DEPTH must be at least 2 and TIMEOUT nonzero");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, GAP, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d;
  logic [CNT_W-1:0]      left_q, left_d, total_q, total_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic                  wr_pass_q, wr_pass_d;
  logic                  rd_follow_q, rd_follow_d;
  logic                  err_d, tmo_d;
  logic [CNT_W-1:0]      err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_d;
  logic                  hs, tmo_hit;
  logic [CNT_W-1:0]      cnt_clamped;
  logic [WIDTH-1:0]      expected;

  assign hs          = bus.valid & bus.ready;
  assign cnt_clamped = (no_of_loc_i > DEPTH_CNT) ? DEPTH_CNT : no_of_loc_i;
  assign expected    = seed_q + WIDTH'(addr_q);

`ifdef MEM_BIST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Cycles the current request has been waiting for ready.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= (bus.valid && !bus.ready) ? tmo_cnt_q + TMO_W'(1) : '0;
  end

  assign tmo_hit = bus.valid && !bus.ready && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state, sweep bookkeeping and status update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    left_d      = left_q;
    total_d     = total_q;
    seed_d      = seed_q;
    wr_pass_d   = wr_pass_q;
    rd_follow_d = rd_follow_q;
    err_d       = err_o;
    err_cnt_d   = err_cnt_o;
    first_err_d = first_err_addr_o;
    tmo_d       = timeout_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d      = s_loc_i;
          addr_d      = s_loc_i;
          seed_d      = seed_i;
          left_d      = cnt_clamped;
          total_d     = cnt_clamped;
          wr_pass_d   = (mode_i != 2'd1);
          rd_follow_d = mode_i[1];
          err_d       = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          tmo_d       = 1'b0;
          // An empty run spends one idle cycle in GAP so done lines up with a normal pass tail.
          if (cnt_clamped == '0) begin
            rd_follow_d = 1'b0;
            state_d     = GAP;
          end else begin
            state_d = (mode_i == 2'd1) ? RD_REQ : WR_REQ;
          end
        end
      end
      WR_REQ, RD_REQ: begin
        if (hs) begin
          left_d  = left_q - CNT_W'(1);
          state_d = GAP;
          if (state_q == RD_REQ && bus.rdata != expected) begin
            err_d = 1'b1;
            if (err_cnt_o != '1) err_cnt_d = err_cnt_o + CNT_W'(1);
            if (!err_o)          first_err_d = addr_q;
          end
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      GAP: begin
        if (left_q == '0) begin
          if (rd_follow_q) begin
            rd_follow_d = 1'b0;
            wr_pass_d   = 1'b0;
            addr_d      = base_q;
            left_d      = total_q;
            state_d     = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end else begin
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
          state_d = wr_pass_q ? WR_REQ : RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs (request fields derived from the next state).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      base_q           <= '0;
      left_q           <= '0;
      total_q          <= '0;
      seed_q           <= '0;
      wr_pass_q        <= 1'b0;
      rd_follow_q      <= 1'b0;
      bus.valid        <= 1'b0;
      bus.wr_rd        <= 1'b0;
      bus.addr         <= '0;
      bus.wdata        <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      timeout_o        <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      base_q           <= base_d;
      left_q           <= left_d;
      total_q          <= total_d;
      seed_q           <= seed_d;
      wr_pass_q        <= wr_pass_d;
      rd_follow_q      <= rd_follow_d;
      bus.valid        <= (state_d == WR_REQ) || (state_d == RD_REQ);
      bus.wr_rd        <= (state_d == WR_REQ);
      bus.addr         <= addr_d;
      bus.wdata        <= (state_d == WR_REQ) ? seed_d + WIDTH'(addr_d) : '0;
      busy_o           <= (state_d == WR_REQ) || (state_d == RD_REQ) || (state_d == GAP);
      done_o           <= (state_d == DONE);
      err_o            <= err_d;
      err_cnt_o        <= err_cnt_d;
      first_err_addr_o <= first_err_d;
      timeout_o        <= tmo_d;
    end
  end
endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: behavioural memory responder plus a scoreboard monitor on handshakes and done.
module tb_mem_bist_master;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [WIDTH-1:0] wdata; } xfer_t;
  typedef struct packed { logic err; logic [AW:0] cnt; logic [AW-1:0] first; logic tmo; } stat_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        mode_i = '0;
  logic [AW-1:0]     s_loc_i = '0;
  logic [AW:0]       no_of_loc_i = '0;
  logic [WIDTH-1:0]  seed_i = '0;
  logic              busy_o, done_o, err_o, timeout_o;
  logic [AW:0]       err_cnt_o;
  logic [AW-1:0]     first_err_addr_o;

  mem_bist_master_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  mem_bist_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .s_loc_i(s_loc_i),
    .no_of_loc_i(no_of_loc_i), .seed_i(seed_i), .bus(bus), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o)
  );

  int               n_checks = 0;
  int               n_fail = 0;
  xfer_t            sb_q[$];
  stat_t            done_q[$];
  logic [WIDTH-1:0] mem [DEPTH];
  int               lat = 0;
  logic             hold_ready = 1'b0;
  logic             run_first = 1'b1;
  logic [WIDTH-1:0] wdata_at5 = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory responder: raises ready after lat cycles of valid, commits writes after the handshake edge.
  initial begin
    xfer_t cap;
    int    wcnt;
    wcnt = 0;
    cap = '0;
    bus.ready = 1'b0;
    bus.rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        bus.ready = 1'b0;
        wcnt = 0;
      end else if (bus.ready) begin
        if (cap.wr) mem[cap.addr] = cap.wdata;
        bus.ready = 1'b0;
        wcnt = 0;
      end else if (bus.valid && !hold_ready) begin
        if (wcnt == lat) begin
          cap.wr    = bus.wr_rd;
          cap.addr  = bus.addr;
          cap.wdata = bus.wdata;
          bus.rdata = mem[bus.addr];
          bus.ready = 1'b1;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and on each done pulse.
  initial begin
    xfer_t exp_x;
    stat_t exp_s;
    logic  prev_valid;
    int    low_cnt;
    prev_valid = 1'b0;
    low_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (bus.valid && bus.ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_xfer", 32'({bus.wr_rd, bus.addr, bus.wdata}), 32'h0);
          end else begin
            exp_x = sb_q.pop_front();
            chk("xfer", 32'({bus.wr_rd, bus.addr, bus.wdata}), 32'(exp_x));
          end
          if (bus.wr_rd && bus.addr == AW'(5)) wdata_at5 = bus.wdata;
        end
        if (bus.valid && !prev_valid) begin
          if (!run_first) chk("gap_cycles", 32'(low_cnt), 32'd1);
          run_first = 1'b0;
        end
        low_cnt = bus.valid ? 0 : low_cnt + 1;
        if (done_o) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(done_o), 32'h0);
          end else begin
            exp_s = done_q.pop_front();
            chk("done_err", 32'(err_o), 32'(exp_s.err));
            chk("done_err_cnt", 32'(err_cnt_o), 32'(exp_s.cnt));
            chk("done_first_err", 32'(first_err_addr_o), 32'(exp_s.first));
            chk("done_timeout", 32'(timeout_o), 32'(exp_s.tmo));
          end
        end
      end
      prev_valid = bus.valid;
    end
  end

  task automatic push_pass(input logic wr, input int sloc, input int n, input logic [WIDTH-1:0] seed);
    xfer_t x;
    for (int i = 0; i < n; i++) begin
      x.wr    = wr;
      x.addr  = AW'((sloc + i) % int'(DEPTH));
      x.wdata = wr ? seed + WIDTH'(x.addr) : '0;
      sb_q.push_back(x);
    end
  endtask

  task automatic push_stat(input logic err, input int cnt, input int first, input logic tmo);
    stat_t s;
    s.err = err;
    s.cnt = (AW+1)'(cnt);
    s.first = AW'(first);
    s.tmo = tmo;
    done_q.push_back(s);
  endtask

  task automatic start_run(input logic [1:0] mode, input int sloc, input int cnt,
                           input logic [WIDTH-1:0] seed, input logic exp_valid);
    @(negedge clk_i);
    mode_i = mode;
    s_loc_i = AW'(sloc);
    no_of_loc_i = (AW+1)'(cnt);
    seed_i = seed;
    start_i = 1'b1;
    run_first = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    mode_i = ~mode;
    s_loc_i = ~AW'(sloc);
    no_of_loc_i = '0;
    seed_i = ~seed;
    chk("first_valid", 32'(bus.valid), 32'(exp_valid));
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (!done_o && cyc < limit) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    if (done_o) begin
      chk("busy_at_done", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      chk("done_pulse", 32'(done_o), 32'd0);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
  endtask

  logic [AW-1:0]    t2_addr [8];
  logic [WIDTH-1:0] t2_data [8];

  initial begin
    int    cyc;
    int    hi;
    xfer_t x;
    t2_addr = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1, 6'd2, 6'd3};
    t2_data = '{16'h012C, 16'h012D, 16'h012E, 16'h012F, 16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3};

    // Reset state
    @(negedge clk_i);
    #2;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("rst_first", 32'(first_err_addr_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    rst_i = 1'b1;

    // Full write-then-read sweep
    lat = 0;
    push_pass(1'b1, 0, 64, 16'h1234);
    push_pass(1'b0, 0, 64, 16'h1234);
    push_stat(1'b0, 0, 0, 1'b0);
    start_run(2'd2, 0, 64, 16'h1234, 1'b1);
    wait_done(2000, cyc);
    chk("wdata_at_addr5", 32'(wdata_at5), 32'h1239);

    // Write seed 0, corrupt one word, read-check
    lat = 1;
    push_pass(1'b1, 0, 64, 16'h0000);
    push_stat(1'b0, 0, 0, 1'b0);
    start_run(2'd0, 0, 64, 16'h0000, 1'b1);
    wait_done(2000, cyc);
    mem[10] = 16'hFFFF;
    push_pass(1'b0, 0, 64, 16'h0000);
    push_stat(1'b1, 1, 10, 1'b0);
    start_run(2'd1, 0, 64, 16'h0000, 1'b1);
    wait_done(2000, cyc);
    chk("hold_err", 32'(err_o), 32'd1);
    chk("hold_err_cnt", 32'(err_cnt_o), 32'd1);
    chk("hold_first", 32'(first_err_addr_o), 32'd10);

    // Second corruption: count 2, first address stays at the earlier one
    lat = 2;
    mem[40] = 16'h1234;
    push_pass(1'b0, 0, 64, 16'h0000);
    push_stat(1'b1, 2, 10, 1'b0);
    start_run(2'd1, 0, 64, 16'h0000, 1'b1);
    wait_done(2000, cyc);

    // Asynchronous reset mid read pass at address 20
    lat = 0;
    push_pass(1'b0, 0, 64, 16'h0000);
    start_run(2'd1, 0, 64, 16'h0000, 1'b1);
    for (int k = 0; k < 500; k++) begin
      if (bus.valid && bus.addr == AW'(20)) break;
      @(negedge clk_i);
    end
    chk("reach_addr20", 32'(bus.valid && bus.addr == AW'(20)), 32'd1);
    chk("err_before_reset", 32'(err_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("midrst_first", 32'(first_err_addr_o), 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk_i);
    #1;
    rst_i = 1'b1;

    // Wrapping window 60..3, both passes, hand-computed pattern
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      x.wr = 1'b1; x.addr = t2_addr[i]; x.wdata = t2_data[i];
      sb_q.push_back(x);
    end
    for (int i = 0; i < 8; i++) begin
      x.wr = 1'b0; x.addr = t2_addr[i]; x.wdata = '0;
      sb_q.push_back(x);
    end
    push_stat(1'b0, 0, 0, 1'b0);
    start_run(2'd2, 60, 8, 16'h00F0, 1'b1);
    wait_done(500, cyc);

    // Zero count: no requests, done two cycles after start
    push_stat(1'b0, 0, 0, 1'b0);
    start_run(2'd2, 5, 0, 16'h5555, 1'b0);
    wait_done(20, cyc);
    chk("zero_done_latency", 32'(cyc), 32'd2);

    // Count above DEPTH clamps to 64 per pass; reserved mode behaves as mode 2
    lat = 0;
    push_pass(1'b1, 7, 64, 16'hABCD);
    push_pass(1'b0, 7, 64, 16'hABCD);
    push_stat(1'b0, 0, 0, 1'b0);
    start_run(2'd3, 7, 100, 16'hABCD, 1'b1);
    wait_done(2000, cyc);

    // Memory never answers
    hold_ready = 1'b1;
`ifdef MEM_BIST_TIMEOUT_EN
    push_stat(1'b0, 0, 0, 1'b1);
    start_run(2'd0, 3, 4, 16'h0005, 1'b1);
    hi = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (done_o) break;
      if (bus.valid) hi++;
    end
    chk("tmo_valid_cycles", 32'(hi), 32'd32);
    chk("tmo_flag", 32'(timeout_o), 32'd1);
    wait_done(5, cyc);
`else
    start_run(2'd0, 3, 4, 16'h0005, 1'b1);
    hi = 1;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.valid) hi++;
    end
    chk("valid_held", 32'(hi), 32'd41);
    chk("no_timeout_flag", 32'(timeout_o), 32'd0);
    chk("still_busy", 32'(busy_o), 32'd1);
    #2;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    rst_i = 1'b1;
`endif
    hold_ready = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
